reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 23 ++
 rtl/reg_dump.sv | 141 ++++++++++++++
 tb/tb_reg_dump.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_pkg
//  Description : Shared CPU constants for the register-dump block: register
//                file geometry and the dump FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    // Register file geometry
    localparam int c_NUM_REGS = 32;
    localparam int c_IDX_W    = 5;
    localparam int c_DATA_W   = 32;

    // Dump FSM state encoding
    localparam int          c_ST_W    = 2;
    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_READ = 2'd1;
    localparam logic [1:0]  c_ST_HOLD = 2'd2;
    localparam logic [1:0]  c_ST_FIN  = 2'd3;

endpackage : reg_dump_pkg
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump
//  Description : Walks the register file from FIRST_REG to LAST_REG through an
//                external combinational read port and streams each value out
//                over a valid/ready interface, one word per READ/HOLD pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic                  abort,
    output logic [c_IDX_W-1:0]    rd_addr,
    input  logic [c_DATA_W-1:0]   rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [c_DATA_W-1:0]   out_data,
    output logic [c_IDX_W-1:0]    out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // Index bounds, clamped to the register file so idx can never run past it
    localparam int c_LAST_INT  = (LAST_REG < c_NUM_REGS) ? LAST_REG : (c_NUM_REGS - 1);
    localparam int c_FIRST_INT = (FIRST_REG < c_LAST_INT) ? FIRST_REG : c_LAST_INT;
    localparam logic [c_IDX_W-1:0] c_FIRST_IDX = c_IDX_W'(c_FIRST_INT);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_LAST_INT);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_next_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_out_valid;
    logic [c_DATA_W-1:0] r_out_data;
    logic [c_IDX_W-1:0]  r_out_idx;

    logic w_handshake;
    logic w_at_last;

    assign w_handshake = r_out_valid & out_ready;
    assign w_at_last   = (r_idx == c_LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort wins over everything, including start in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!abort && start) begin
                    w_next_state = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_next_state = abort ? c_ST_IDLE : c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_handshake) begin
                    w_next_state = w_at_last ? c_ST_FIN : c_ST_READ;
                end
            end
            c_ST_FIN: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Index counter and output word capture/hold
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!abort && start) begin
                        r_idx <= c_FIRST_IDX;
                    end
                end
                c_ST_READ: begin
                    // The word is sampled here, so a write landing on this
                    // same edge is not seen
                    if (!abort) begin
                        r_out_data  <= rd_data;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (abort || w_handshake) begin
                        r_out_valid <= 1'b0;
                    end
                    // Increment stops at the last index, so no wrap at 31
                    if (!abort && w_handshake && !w_at_last) begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Moore-style outputs decoded from state; done is masked by a late abort
    always_comb begin
        rd_addr  = '0;
        busy     = (r_state != c_ST_IDLE);
        done     = (r_state == c_ST_FIN) && !abort;
        out_last = r_out_valid && (r_out_idx == c_LAST_IDX);
        if ((r_state == c_ST_READ) || (r_state == c_ST_HOLD)) begin
            rd_addr = r_idx;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;

endmodule : reg_dump
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump
//  Description : Bench for reg_dump: two instances (full range and a single
//                register) share a register-file model; expected words are
//                queued when a dump starts and popped by per-instance monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clrn;
    logic start0, abort0, ready0;
    logic start1, abort1, ready1;

    logic [4:0]  rd_addr0, rd_addr1, idx0, idx1;
    logic [31:0] rd_data0, rd_data1, data0, data1;
    logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

    // Register file under dump, and the bench's own view of its contents
    logic [31:0] regs  [32];
    logic [31:0] mregs [32];

    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'h0 : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];

    reg_dump u_dut0 (
        .clk(clk), .clrn(clrn), .start(start0), .abort(abort0),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(valid0), .out_ready(ready0), .out_data(data0),
        .out_idx(idx0), .out_last(last0), .busy(busy0), .done(done0)
    );

    reg_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut1 (
        .clk(clk), .clrn(clrn), .start(start1), .abort(abort1),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_idx(idx1), .out_last(last1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    word_t q0[$];
    word_t q1[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the words a dump of [first..last] must produce, from current contents
    task automatic push_dump(input int which, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            word_t w;
            w.idx  = 5'(i);
            w.data = (i == 0) ? 32'h0 : mregs[i];
            w.last = (i == last);
            if (which == 0) q0.push_back(w);
            else            q1.push_back(w);
        end
    endtask

    // ---------------- Monitor for instance 0 ----------------
    logic        pend0, stall0;
    logic [31:0] pdata0;
    logic [4:0]  pidx0;
    int          done_cnt0 = 0;
    word_t       e0;
    always @(negedge clk) begin
        logic nxt;
        nxt = 1'b0;
        if (!clrn) begin
            pend0  = 1'b0;
            stall0 = 1'b0;
        end else begin
            if (valid0 && stall0) begin
                check("dut0_hold_data", data0, pdata0);
                check("dut0_hold_idx", {27'd0, idx0}, {27'd0, pidx0});
            end
            check("dut0_done", {31'd0, done0}, {31'd0, pend0 && !abort0});
            if (done0) done_cnt0++;
            if (valid0 && ready0) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut0_unexpected_word: got idx %0d data 0x%08h, required no word", idx0, data0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0_idx", {27'd0, idx0}, {27'd0, e0.idx});
                    check("dut0_data", data0, e0.data);
                    check("dut0_last", {31'd0, last0}, {31'd0, e0.last});
                    nxt = e0.last && !abort0;
                end
            end
            pend0  = nxt;
            stall0 = valid0 && !ready0;
            pdata0 = data0;
            pidx0  = idx0;
        end
    end

    // ---------------- Monitor for instance 1 ----------------
    logic        pend1, stall1;
    logic [31:0] pdata1;
    int          done_cnt1 = 0;
    word_t       e1;
    always @(negedge clk) begin
        logic nxt;
        nxt = 1'b0;
        if (!clrn) begin
            pend1  = 1'b0;
            stall1 = 1'b0;
        end else begin
            if (valid1 && stall1) check("dut1_hold_data", data1, pdata1);
            check("dut1_done", {31'd0, done1}, {31'd0, pend1 && !abort1});
            if (done1) done_cnt1++;
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut1_unexpected_word: got idx %0d data 0x%08h, required no word", idx1, data1);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_idx", {27'd0, idx1}, {27'd0, e1.idx});
                    check("dut1_data", data1, e1.data);
                    check("dut1_last", {31'd0, last1}, {31'd0, e1.last});
                    nxt = e1.last && !abort1;
                end
            end
            pend1  = nxt;
            stall1 = valid1 && !ready1;
            pdata1 = data1;
        end
    end

    task automatic drain0(input string name, input int max);
        int n = 0;
        while ((busy0 || q0.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check({name, "_in_time"}, {31'd0, n < max}, 32'd1);
        check({name, "_queue_empty"}, q0.size(), 32'd0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_valid"}, {31'd0, valid0}, 32'd0);
        check({tag, "_data"}, data0, 32'd0);
        check({tag, "_idx"}, {27'd0, idx0}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_rd_addr"}, {27'd0, rd_addr0}, 32'd0);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int abort_at;
        clrn = 1'b0;
        start0 = 0; abort0 = 0; ready0 = 0;
        start1 = 0; abort1 = 0; ready1 = 0;
        for (int i = 0; i < 32; i++) begin
            regs[i]  <= 32'hA5A50000 + 32'(i);
            mregs[i]  = 32'hA5A50000 + 32'(i);
        end
        repeat (3) tick();
        check_zero0("reset");
        check("reset_dut1_busy", {31'd0, busy1}, 32'd0);
        clrn = 1'b1;
        repeat (2) tick();

        // Full dump with the sink always ready: latency and completion timing
        ready0 = 1;
        push_dump(0, 0, 31);
        start0 = 1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) start0 = 0;
        end while (!valid0 && n < 10);
        check("first_valid_latency", n, 32'd2);
        while (!done0 && n < 200) begin
            tick();
            n++;
        end
        check("done_cycle", n, 32'd65);
        tick();
        check("busy_after_done", {31'd0, busy0}, 32'd0);
        check("full_dump_queue_empty", q0.size(), 32'd0);

        // Back-pressure on idx 3 for five cycles
        push_dump(0, 0, 31);
        start0 = 1;
        tick();
        start0 = 0;
        n = 0;
        while (!(valid0 && idx0 == 5'd3) && n < 50) begin
            tick();
            n++;
        end
        ready0 = 0;
        for (int k = 0; k < 5; k++) begin
            check("bp_data_held", data0, 32'hA5A50003);
            check("bp_valid_held", {31'd0, valid0}, 32'd1);
            tick();
        end
        ready0 = 1;
        drain0("bp_drain", 200);

        // Abort at idx 7 while stalled, then restart from idx 0
        push_dump(0, 0, 31);
        start0 = 1;
        tick();
        start0 = 0;
        n = 0;
        while (!(valid0 && idx0 == 5'd7) && n < 50) begin
            tick();
            n++;
        end
        ready0 = 0;
        abort0 = 1;
        tick();
        abort0 = 0;
        q0.delete();
        check("abort_valid_low", {31'd0, valid0}, 32'd0);
        check("abort_busy_low", {31'd0, busy0}, 32'd0);
        repeat (3) tick();
        ready0 = 1;
        push_dump(0, 0, 31);
        start0 = 1;
        tick();
        start0 = 0;
        drain0("restart_drain", 200);

        // Abort has priority over start in IDLE
        start0 = 1;
        abort0 = 1;
        tick();
        start0 = 0;
        abort0 = 0;
        check("abort_beats_start", {31'd0, busy0}, 32'd0);

        // Reset mid-dump at idx 12
        push_dump(0, 0, 31);
        start0 = 1;
        tick();
        start0 = 0;
        n = 0;
        while (!(valid0 && idx0 == 5'd12) && n < 50) begin
            tick();
            n++;
        end
        clrn = 0;
        #1;
        check_zero0("midreset");
        q0.delete();
        repeat (2) tick();
        clrn = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_reset_no_word", {31'd0, valid0 | busy0}, 32'd0);
        end

        // Write to reg 9 on the edge that closes its READ cycle
        push_dump(0, 0, 31);
        start0 = 1;
        tick();
        start0 = 0;
        n = 0;
        while (!(busy0 && !valid0 && rd_addr0 == 5'd9) && n < 50) begin
            tick();
            n++;
        end
        @(posedge clk);
        regs[9] <= 32'h12345678;
        mregs[9] = 32'h12345678;
        #1;
        drain0("write_drain", 200);

        // Randomized sink stalls, random aborts and ignored extra starts
        for (int d = 0; d < 6; d++) begin
            push_dump(0, 0, 31);
            start0 = 1;
            tick();
            start0 = 0;
            abort_at = $urandom_range(0, 220);
            n = 0;
            while ((busy0 || q0.size() != 0) && n < 400) begin
                ready0 = 1'($urandom_range(0, 1));
                start0 = busy0 && ($urandom_range(0, 7) == 0);
                if (n == abort_at && busy0) begin
                    abort0 = 1;
                    tick();
                    abort0 = 0;
                    start0 = 0;
                    q0.delete();
                    check("rand_abort_idle", {31'd0, busy0}, 32'd0);
                end else begin
                    tick();
                end
                n++;
            end
            start0 = 0;
            check("rand_in_time", {31'd0, n < 400}, 32'd1);
            check("rand_queue_empty", q0.size(), 32'd0);
            ready0 = 1;
            tick();
        end

        // Single-register instance with an extra start during busy
        done_cnt1 = 0;
        push_dump(1, 5, 5);
        start1 = 1;
        tick();
        start1 = 0;
        tick();
        check("single_valid", {31'd0, valid1}, 32'd1);
        start1 = 1;
        tick();
        start1 = 0;
        tick();
        ready1 = 1;
        n = 0;
        while ((busy1 || q1.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("single_queue_empty", q1.size(), 32'd0);
        check("single_done_count", done_cnt1, 32'd1);
        check("single_idle", {31'd0, busy1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_dump
`default_nettype wire
